// File: rtl/icache_req_arbiter_pkg.sv
// Shared types for the i-cache request arbiter and the fetch unit.
// Holds the arbiter state encoding and the grant source enum.
package icache_req_arbiter_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY_FETCH,
      ARB_BUSY_PREF,
      ARB_DISCARD
   } icache_arb_state_t;

   typedef enum logic {
      SRC_FETCH,
      SRC_PREF
   } icache_req_src_t;

   function automatic icache_arb_state_t busy_state(icache_req_src_t s);
      return (s == SRC_PREF) ? ARB_BUSY_PREF : ARB_BUSY_FETCH;
   endfunction

endpackage

// File: rtl/icache_req_arbiter.sv
// Shares the single i-cache read port between demand fetch and the
// next-line prefetcher, one outstanding read at a time.
// Ports: clk_i/rst_i (async, active-high), flush_i,
//   fetch_req_i/fetch_addr_i/fetch_done_o  demand requester
//   pref_req_i/pref_addr_i/pref_done_o     prefetch requester
//   read_req_o/read_addr_o/read_done_i     i-cache read port
//   busy_o                                 a read is outstanding
module icache_req_arbiter
   import icache_req_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned ADDR_W       = XLEN
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              fetch_req_i,
   input  logic [ADDR_W-1:0] fetch_addr_i,
   output logic              fetch_done_o,
   input  logic              pref_req_i,
   input  logic [ADDR_W-1:0] pref_addr_i,
   output logic              pref_done_o,
   output logic              read_req_o,
   output logic [ADDR_W-1:0] read_addr_o,
   input  logic              read_done_i,
   output logic              busy_o
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   icache_arb_state_t state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   icache_req_src_t   src;
   logic              starved;

   assign starved = (starve_cnt_q == CNT_MAX);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ARB_IDLE;
         addr_q       <= '0;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      starve_cnt_d = starve_cnt_q;
      fetch_done_o = 1'b0;
      pref_done_o  = 1'b0;
      src          = SRC_FETCH;

      unique case (state_q)
         ARB_IDLE: begin
            if (!flush_i && (fetch_req_i || pref_req_i)) begin
               // Prefetch wins alone, or when the starvation
               // budget has been used up by fetch.
               if (pref_req_i && (!fetch_req_i || starved)) begin
                  src = SRC_PREF;
               end
               state_d = busy_state(src);
               if (src == SRC_PREF) begin
                  addr_d       = pref_addr_i;
                  starve_cnt_d = '0;
               end else begin
                  addr_d = fetch_addr_i;
                  if (pref_req_i && !starved) begin
                     starve_cnt_d = starve_cnt_q + CNT_W'(1);
                  end
               end
            end
         end
         ARB_BUSY_FETCH: begin
            if (read_done_i) begin
               fetch_done_o = !flush_i;
               state_d      = ARB_IDLE;
            end else if (flush_i) begin
               state_d = ARB_DISCARD;
            end
         end
         ARB_BUSY_PREF: begin
            if (read_done_i) begin
               pref_done_o = !flush_i;
               state_d     = ARB_IDLE;
            end else if (flush_i) begin
               state_d = ARB_DISCARD;
            end
         end
         ARB_DISCARD: begin
            // The cache cannot cancel; wait out the stale line.
            if (read_done_i) begin
               state_d = ARB_IDLE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      if (flush_i) begin
         starve_cnt_d = '0;
      end
   end

   assign read_req_o  = (state_q != ARB_IDLE);
   assign busy_o      = (state_q != ARB_IDLE);
   assign read_addr_o = addr_q;

endmodule

// File: tb/tb_icache_req_arbiter.sv
// Directed vector table plus hand-written sequences and a random
// stress run for the i-cache request arbiter.
module tb_icache_req_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        flush_i;
   logic        fetch_req_i;
   logic [31:0] fetch_addr_i;
   logic        fetch_done_o;
   logic        pref_req_i;
   logic [31:0] pref_addr_i;
   logic        pref_done_o;
   logic        read_req_o;
   logic [31:0] read_addr_o;
   logic        read_done_i;
   logic        busy_o;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   icache_req_arbiter #(
      .STARVE_LIMIT(8),
      .ADDR_W      (32)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .fetch_req_i (fetch_req_i),
      .fetch_addr_i(fetch_addr_i),
      .fetch_done_o(fetch_done_o),
      .pref_req_i  (pref_req_i),
      .pref_addr_i (pref_addr_i),
      .pref_done_o (pref_done_o),
      .read_req_o  (read_req_o),
      .read_addr_o (read_addr_o),
      .read_done_i (read_done_i),
      .busy_o      (busy_o)
   );

   typedef struct {
      logic        fr;
      logic [31:0] fa;
      logic        pr;
      logic [31:0] pa;
      logic        rd;
      logic        fl;
      logic        rr;
      logic [31:0] ra;
      logic        fd;
      logic        pd;
      logic        by;
   } vec_t;

   localparam int NV = 24;
   vec_t tv [NV];

   function automatic vec_t mk(
      logic fr, logic [31:0] fa, logic pr, logic [31:0] pa,
      logic rd, logic fl,
      logic rr, logic [31:0] ra, logic fd, logic pd, logic by);
      vec_t v;
      v.fr = fr; v.fa = fa; v.pr = pr; v.pa = pa;
      v.rd = rd; v.fl = fl;
      v.rr = rr; v.ra = ra; v.fd = fd; v.pd = pd; v.by = by;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic chk_outs(input string tag, input logic rr,
                           input logic [31:0] ra, input logic fd,
                           input logic pd, input logic by);
      chk({tag, ".read_req"}, 32'(read_req_o), 32'(rr));
      chk({tag, ".read_addr"}, read_addr_o, ra);
      chk({tag, ".fetch_done"}, 32'(fetch_done_o), 32'(fd));
      chk({tag, ".pref_done"}, 32'(pref_done_o), 32'(pd));
      chk({tag, ".busy"}, 32'(busy_o), 32'(by));
   endtask

   task automatic idle_inputs();
      fetch_req_i  = 1'b0;
      pref_req_i   = 1'b0;
      read_done_i  = 1'b0;
      flush_i      = 1'b0;
      fetch_addr_i = '0;
      pref_addr_i  = '0;
   endtask

   initial begin
      int n;
      int grants;
      int comps;
      logic        p_rr;
      logic        p_rd;
      logic [31:0] p_ra;
      logic        fd_seen;
      logic        pd_seen;

      // Cycle-by-cycle vectors: inputs applied after a rising
      // edge, outputs checked on the following falling edge.
      //          fr fa       pr pa       rd fl  rr ra       fd pd by
      tv[0]  = mk(1, 32'h100, 0, 32'h0,   0, 0,  0, 32'h0,   0, 0, 0);
      tv[1]  = mk(1, 32'h100, 0, 32'h0,   0, 0,  1, 32'h100, 0, 0, 1);
      tv[2]  = mk(1, 32'h200, 0, 32'h0,   0, 0,  1, 32'h100, 0, 0, 1);
      tv[3]  = mk(1, 32'h200, 0, 32'h0,   0, 0,  1, 32'h100, 0, 0, 1);
      tv[4]  = mk(1, 32'h200, 0, 32'h0,   1, 0,  1, 32'h100, 1, 0, 1);
      tv[5]  = mk(0, 32'h0,   0, 32'h0,   0, 0,  0, 32'h100, 0, 0, 0);
      tv[6]  = mk(1, 32'h300, 0, 32'h0,   0, 0,  0, 32'h100, 0, 0, 0);
      tv[7]  = mk(1, 32'h300, 0, 32'h0,   0, 1,  1, 32'h300, 0, 0, 1);
      tv[8]  = mk(0, 32'h0,   0, 32'h0,   0, 0,  1, 32'h300, 0, 0, 1);
      tv[9]  = mk(0, 32'h0,   0, 32'h0,   0, 1,  1, 32'h300, 0, 0, 1);
      tv[10] = mk(0, 32'h0,   0, 32'h0,   0, 0,  1, 32'h300, 0, 0, 1);
      tv[11] = mk(0, 32'h0,   0, 32'h0,   1, 0,  1, 32'h300, 0, 0, 1);
      tv[12] = mk(1, 32'h400, 0, 32'h0,   0, 1,  0, 32'h300, 0, 0, 0);
      tv[13] = mk(0, 32'h0,   0, 32'h0,   0, 0,  0, 32'h300, 0, 0, 0);
      tv[14] = mk(0, 32'h0,   1, 32'h500, 0, 0,  0, 32'h300, 0, 0, 0);
      tv[15] = mk(0, 32'h0,   1, 32'h500, 1, 1,  1, 32'h500, 0, 0, 1);
      tv[16] = mk(0, 32'h0,   1, 32'h600, 0, 0,  0, 32'h500, 0, 0, 0);
      tv[17] = mk(0, 32'h0,   1, 32'h600, 1, 0,  1, 32'h600, 0, 1, 1);
      tv[18] = mk(0, 32'h0,   0, 32'h0,   1, 0,  0, 32'h600, 0, 0, 0);
      tv[19] = mk(1, 32'ha00, 1, 32'hb00, 0, 0,  0, 32'h600, 0, 0, 0);
      tv[20] = mk(1, 32'ha00, 1, 32'hb00, 1, 0,  1, 32'ha00, 1, 0, 1);
      tv[21] = mk(0, 32'h0,   1, 32'hb00, 0, 0,  0, 32'ha00, 0, 0, 0);
      tv[22] = mk(0, 32'h0,   1, 32'hb00, 1, 0,  1, 32'hb00, 0, 1, 1);
      tv[23] = mk(0, 32'h0,   0, 32'h0,   0, 0,  0, 32'hb00, 0, 0, 0);

      idle_inputs();
      rst_i = 1'b1;
      #1;
      chk_outs("reset", 0, 32'h0, 0, 0, 0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(posedge clk_i);
         #1;
         fetch_req_i  = tv[i].fr;
         fetch_addr_i = tv[i].fa;
         pref_req_i   = tv[i].pr;
         pref_addr_i  = tv[i].pa;
         read_done_i  = tv[i].rd;
         flush_i      = tv[i].fl;
         @(negedge clk_i);
         chk_outs($sformatf("vec%0d", i), tv[i].rr, tv[i].ra,
                  tv[i].fd, tv[i].pd, tv[i].by);
      end

      // Both requesting, 1-cycle cache: 8 fetch, 1 pref, repeat.
      fetch_req_i  = 1'b1;
      fetch_addr_i = 32'h1000;
      pref_req_i   = 1'b1;
      pref_addr_i  = 32'h2000;
      n = 0;
      for (int c = 0; c < 60 && n < 18; c++) begin
         @(posedge clk_i);
         #1;
         read_done_i = read_req_o;
         @(negedge clk_i);
         chk("starve.onehot", 32'(fetch_done_o & pref_done_o), 32'h0);
         if (fetch_done_o || pref_done_o) begin
            chk($sformatf("starve.src%0d", n), 32'(pref_done_o),
                32'((n % 9) == 8));
            chk($sformatf("starve.addr%0d", n), read_addr_o,
                ((n % 9) == 8) ? 32'h2000 : 32'h1000);
            n++;
         end
      end
      chk("starve.count", 32'(n), 32'd18);
      @(posedge clk_i);
      #1;
      idle_inputs();

      // Asynchronous reset in the middle of a prefetch read.
      @(posedge clk_i);
      #1;
      pref_req_i  = 1'b1;
      pref_addr_i = 32'h700;
      @(posedge clk_i);
      #1;
      chk_outs("rst.pre", 1, 32'h700, 0, 0, 1);
      #3;
      rst_i       = 1'b1;
      read_done_i = 1'b1;
      #1;
      chk_outs("rst.mid", 0, 32'h0, 0, 0, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      idle_inputs();
      @(posedge clk_i);
      #1;
      fetch_req_i  = 1'b1;
      fetch_addr_i = 32'h800;
      @(posedge clk_i);
      #1;
      chk_outs("rst.regrant", 1, 32'h800, 0, 0, 1);
      read_done_i = 1'b1;
      #1;
      chk_outs("rst.done", 1, 32'h800, 1, 0, 1);
      @(posedge clk_i);
      #1;
      idle_inputs();

      // Random stress with a random-latency cache.
      p_rr    = 1'b0;
      p_rd    = 1'b0;
      p_ra    = '0;
      fd_seen = 1'b0;
      pd_seen = 1'b0;
      grants  = 0;
      comps   = 0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk_i);
         #1;
         if (fd_seen) fetch_req_i = 1'b0;
         else if (!fetch_req_i) fetch_req_i = ($urandom_range(0, 2) == 0);
         if (pd_seen) pref_req_i = 1'b0;
         else if (!pref_req_i) pref_req_i = ($urandom_range(0, 2) == 0);
         fetch_addr_i = $urandom;
         pref_addr_i  = $urandom;
         flush_i      = ($urandom_range(0, 15) == 0);
         read_done_i  = read_req_o && ($urandom_range(0, 2) == 0);
         @(negedge clk_i);
         fd_seen = fetch_done_o;
         pd_seen = pref_done_o;
         chk("rand.onehot", 32'(fetch_done_o & pref_done_o), 32'h0);
         if (fetch_done_o || pref_done_o) begin
            chk("rand.done_needs_rd", 32'(read_done_i), 32'h1);
         end
         if (read_req_o && p_rr && !p_rd) begin
            chk("rand.addr_stable", read_addr_o, p_ra);
         end
         if (read_req_o && !p_rr) grants++;
         if (read_req_o && read_done_i) comps++;
         p_rr = read_req_o;
         p_rd = read_done_i;
         p_ra = read_addr_o;
      end

      // Drain: stop requesting, answer whatever is outstanding.
      @(posedge clk_i);
      #1;
      fetch_req_i = 1'b0;
      pref_req_i  = 1'b0;
      flush_i     = 1'b0;
      read_done_i = 1'b0;
      if (p_rr && p_rd) p_rr = 1'b0;
      for (int c = 0; c < 50 && read_req_o; c++) begin
         read_done_i = 1'b1;
         @(negedge clk_i);
         if (read_req_o && !p_rr) grants++;
         comps++;
         p_rr = 1'b0;
         @(posedge clk_i);
         #1;
         read_done_i = 1'b0;
      end
      chk("drain.idle", 32'(read_req_o), 32'h0);
      chk("rand.grants_complete", 32'(comps), 32'(grants));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
